// File: rtl/rv_test_monitor.sv
// Purpose : end-of-test monitor; snoops stores, reg-file writes and retires to give a pass/fail/timeout verdict.
// Latency : verdict outputs registered, visible one cycle after the trigger cycle; counters update every RUN cycle.
// Backpr. : none, purely passive snooper; never stalls the core it watches.
//
// Ports:
//   clk_sys, rst_n            clock, async active-low reset
//   start                     one-cycle pulse, clears and arms the monitor
//   dbus_we/addr/wdata        data-store bus (tohost detection)
//   rf_we/waddr/wdata         register-file write port (gp shadow)
//   ret_valid/ret_pc          retire stream (self-loop detection)
//   done/pass/timeout         sticky verdict flags
//   test_num                  failing test number, 0 on pass or timeout
//   cycle_cnt/retire_cnt      RUN cycles and retired instructions, frozen at verdict
module rv_test_monitor #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter bit                EN_TOHOST      = 1'b1,
    parameter bit                EN_LOOP        = 1'b1,
    parameter int                LOOP_LIMIT     = 8,
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                CNT_W          = 32
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dbus_we,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_wdata,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_pc,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] test_num,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int LC_W = $clog2(LOOP_LIMIT + 1);
    localparam logic [LC_W-1:0]   LOOP_MAX = LC_W'(LOOP_LIMIT);
    localparam logic [CNT_W-1:0]  TOUT_AT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cycle_cnt_q,  cycle_cnt_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic [DATA_W-1:0]  gp_shadow_q,  gp_shadow_d;
    logic [ADDR_W-1:0]  last_pc_q,    last_pc_d;
    logic [LC_W-1:0]    loop_cnt_q,   loop_cnt_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    logic               timeout_q,    timeout_d;
    logic [DATA_W-1:0]  test_num_q,   test_num_d;

    logic               gp_wr;
    logic [DATA_W-1:0]  gp_eff;
    logic [LC_W-1:0]    loop_cnt_nxt;
    logic               tohost_hit;
    logic               loop_hit;
    logic               tout_hit;

    always_comb begin
        gp_wr  = rf_we && (rf_waddr == 5'd3);
        // A gp write landing in the same cycle as the final loop retire must be seen.
        gp_eff = gp_wr ? rf_wdata : gp_shadow_q;

        // Saturating at the limit keeps the count sane when loop detection is disabled.
        if (ret_pc == last_pc_q) begin
            loop_cnt_nxt = (loop_cnt_q == LOOP_MAX) ? loop_cnt_q : loop_cnt_q + 1'b1;
        end else begin
            loop_cnt_nxt = LC_W'(1);
        end

        tohost_hit = EN_TOHOST && dbus_we && (dbus_addr == TOHOST_ADDR) && dbus_wdata[0];
        loop_hit   = EN_LOOP && ret_valid && (loop_cnt_nxt == LOOP_MAX);
        tout_hit   = (cycle_cnt_q == TOUT_AT);

        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        gp_shadow_d  = gp_shadow_q;
        last_pc_d    = last_pc_q;
        loop_cnt_d   = loop_cnt_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        test_num_d   = test_num_q;

        if (start) begin
            // start overrides any trigger seen in the same cycle
            state_d      = S_RUN;
            cycle_cnt_d  = '0;
            retire_cnt_d = '0;
            gp_shadow_d  = '0;
            loop_cnt_d   = '0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
            test_num_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    // The trigger cycle itself is included in both counts.
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                    if (ret_valid && (retire_cnt_q != '1)) begin
                        retire_cnt_d = retire_cnt_q + 1'b1;
                    end
                    if (gp_wr) begin
                        gp_shadow_d = rf_wdata;
                    end
                    if (ret_valid) begin
                        loop_cnt_d = loop_cnt_nxt;
                        last_pc_d  = ret_pc;
                    end

                    if (tohost_hit) begin
                        done_d = 1'b1;
                        if (dbus_wdata == ONE) begin
                            state_d = S_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            state_d    = S_FAIL;
                            test_num_d = dbus_wdata >> 1;
                        end
                    end else if (loop_hit) begin
                        done_d = 1'b1;
                        if (gp_eff == ONE) begin
                            state_d = S_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            state_d    = S_FAIL;
                            test_num_d = gp_eff >> 1;
                        end
                    end else if (tout_hit) begin
                        state_d   = S_TOUT;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                S_IDLE, S_PASS, S_FAIL, S_TOUT: begin
                    // snooped inputs ignored; verdict and counters hold
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            gp_shadow_q  <= '0;
            last_pc_q    <= '0;
            loop_cnt_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            test_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            gp_shadow_q  <= gp_shadow_d;
            last_pc_q    <= last_pc_d;
            loop_cnt_q   <= loop_cnt_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            test_num_q   <= test_num_d;
        end
    end

    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign test_num   = test_num_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Purpose : directed self-checking bench for rv_test_monitor.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge after the active edge.
// Backpr. : not applicable.
module tb_rv_test_monitor;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] test_num;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    rv_test_monitor dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .start      (start),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .ret_valid  (ret_valid),
        .ret_pc     (ret_pc),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .test_num   (test_num),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    task automatic clear_inputs();
        start      = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_wdata = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        ret_valid  = 1'b0;
        ret_pc     = '0;
    endtask

    // Applies one cycle of snooped traffic, starting and ending on a falling edge.
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rwe, input logic [4:0] ra, input logic [31:0] rd,
                         input logic rv, input logic [31:0] pc);
        dbus_we    = we;
        dbus_addr  = addr;
        dbus_wdata = wdata;
        rf_we      = rwe;
        rf_waddr   = ra;
        rf_wdata   = rd;
        ret_valid  = rv;
        ret_pc     = pc;
        @(posedge clk_sys);
        @(negedge clk_sys);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        n_checks++;
        if ({done, pass, timeout} !== 3'b000 || test_num !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got d/p/t=%b%b%b num=%0d, want 000 num=0", done, pass, timeout, test_num);
        end
        n_checks++;
        if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnts: got cyc=%0d ret=%0d, want 0 0", cycle_cnt, retire_cnt);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        // IDLE must ignore traffic, including a passing tohost store
        drive(1'b1, 32'h1000, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100);
        idle(2);
        n_checks++;
        if (done !== 1'b0 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_ignores: got done=%b cyc=%0d ret=%0d, want 0 0 0", done, cycle_cnt, retire_cnt);
        end
    endtask

    task automatic test_tohost_pass();
        do_start();
        n_checks++;
        if (done !== 1'b0 || cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL start_clear: got done=%b cyc=%0d, want 0 0", done, cycle_cnt);
        end
        idle(10);                                                      // RUN cycles 0..9
        drive(1'b1, 32'h1000, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);  // cycle 10: lsb clear, ignored
        drive(1'b1, 32'h1004, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);  // cycle 11: wrong address
        idle(38);                                                      // cycles 12..49
        n_checks++;
        if (done !== 1'b0 || cycle_cnt !== 32'd50) begin
            n_fail++;
            $display("FAIL tohost_pre: got done=%b cyc=%0d, want 0 50", done, cycle_cnt);
        end
        drive(1'b1, 32'h1000, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);  // cycle 50
        n_checks++;
        if ({done, pass, timeout} !== 3'b110 || test_num !== 32'd0) begin
            n_fail++;
            $display("FAIL tohost_pass: got d/p/t=%b%b%b num=%0d, want 110 num=0", done, pass, timeout, test_num);
        end
        n_checks++;
        if (cycle_cnt !== 32'd51 || retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL tohost_cnt: got cyc=%0d ret=%0d, want 51 0", cycle_cnt, retire_cnt);
        end
        idle(5);
        n_checks++;
        if (cycle_cnt !== 32'd51 || {done, pass} !== 2'b11) begin
            n_fail++;
            $display("FAIL tohost_hold: got cyc=%0d d/p=%b%b, want 51 11", cycle_cnt, done, pass);
        end
    endtask

    task automatic test_loop_fail();
        do_start();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h0B, 1'b0, 32'h0);    // cycle 0: gp = 0x0B
        for (int i = 0; i < 7; i++) begin
            // x4 writes must not disturb the gp shadow
            drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 32'h1, 1'b1, 32'h200);
        end
        n_checks++;
        if (done !== 1'b0 || retire_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL loop_pre: got done=%b ret=%0d, want 0 7", done, retire_cnt);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h200);   // cycle 8: 8th retire
        n_checks++;
        if ({done, pass, timeout} !== 3'b100 || test_num !== 32'd5) begin
            n_fail++;
            $display("FAIL loop_fail: got d/p/t=%b%b%b num=%0d, want 100 num=5", done, pass, timeout, test_num);
        end
        n_checks++;
        if (cycle_cnt !== 32'd9 || retire_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL loop_fail_cnt: got cyc=%0d ret=%0d, want 9 8", cycle_cnt, retire_cnt);
        end
    endtask

    task automatic test_loop_interleave();
        do_start();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1, 1'b0, 32'h0);     // cycle 0: gp = 1
        // 5th retire breaks the run; 6th restarts at 1 so the 13th retire hits 8
        for (int k = 1; k <= 13; k++) begin
            if (k == 13) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL loop_restart_early: got done=%b before 13th retire, want 0", done);
                end
            end
            drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, (k == 5) ? 32'h304 : 32'h300);
            if (k < 13) idle(1);
        end
        n_checks++;
        if ({done, pass, timeout} !== 3'b110 || test_num !== 32'd0) begin
            n_fail++;
            $display("FAIL loop_pass: got d/p/t=%b%b%b num=%0d, want 110 num=0", done, pass, timeout, test_num);
        end
        n_checks++;
        if (cycle_cnt !== 32'd26 || retire_cnt !== 32'd13) begin
            n_fail++;
            $display("FAIL loop_pass_cnt: got cyc=%0d ret=%0d, want 26 13", cycle_cnt, retire_cnt);
        end
    endtask

    task automatic test_same_cycle();
        do_start();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h400);
        end
        drive(1'b1, 32'h1000, 32'h7, 1'b0, 5'd0, 32'h0, 1'b1, 32'h400);
        n_checks++;
        if ({done, pass, timeout} !== 3'b100 || test_num !== 32'd3) begin
            n_fail++;
            $display("FAIL tohost_priority: got d/p/t=%b%b%b num=%0d, want 100 num=3", done, pass, timeout, test_num);
        end
    endtask

    task automatic test_gp_bypass();
        do_start();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h5, 1'b0, 32'h0);     // stale gp = 5
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h500);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1, 1'b1, 32'h500);   // gp = 1 on final retire
        n_checks++;
        if ({done, pass, timeout} !== 3'b110 || test_num !== 32'd0) begin
            n_fail++;
            $display("FAIL gp_bypass: got d/p/t=%b%b%b num=%0d, want 110 num=0", done, pass, timeout, test_num);
        end
    endtask

    task automatic test_timeout();
        do_start();
        idle(999);
        n_checks++;
        if (done !== 1'b0 || cycle_cnt !== 32'd999) begin
            n_fail++;
            $display("FAIL tout_pre: got done=%b cyc=%0d, want 0 999", done, cycle_cnt);
        end
        idle(1);
        n_checks++;
        if ({done, pass, timeout} !== 3'b101 || test_num !== 32'd0 || cycle_cnt !== 32'd1000) begin
            n_fail++;
            $display("FAIL tout: got d/p/t=%b%b%b num=%0d cyc=%0d, want 101 num=0 cyc=1000",
                     done, pass, timeout, test_num, cycle_cnt);
        end
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h1000, 32'h1, 1'b1, 5'd3, 32'h1, 1'b1, 32'h600);
        end
        n_checks++;
        if ({done, pass, timeout} !== 3'b101 || cycle_cnt !== 32'd1000 || retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL tout_frozen: got d/p/t=%b%b%b cyc=%0d ret=%0d, want 101 1000 0",
                     done, pass, timeout, cycle_cnt, retire_cnt);
        end
    endtask

    task automatic test_start_priority();
        // start together with a passing tohost store: rearm wins, no verdict
        start = 1'b1;
        drive(1'b1, 32'h1000, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h700);
        n_checks++;
        if ({done, pass, timeout} !== 3'b000 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL start_priority: got d/p/t=%b%b%b cyc=%0d ret=%0d, want 000 0 0",
                     done, pass, timeout, cycle_cnt, retire_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h800 + 32'(4 * i));
        end
        n_checks++;
        if (cycle_cnt !== 32'd10 || retire_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL midrun_cnt: got cyc=%0d ret=%0d, want 10 10", cycle_cnt, retire_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cyc=%0d ret=%0d done=%b, want 0 0 0", cycle_cnt, retire_cnt, done);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        drive(1'b1, 32'h1000, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (done !== 1'b0 || cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got done=%b cyc=%0d, want 0 0", done, cycle_cnt);
        end
        do_start();
        idle(3);
        n_checks++;
        if (cycle_cnt !== 32'd3 || retire_cnt !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm: got cyc=%0d ret=%0d done=%b, want 3 0 0", cycle_cnt, retire_cnt, done);
        end
    endtask

    initial begin
        test_reset();
        test_tohost_pass();
        test_loop_fail();
        test_loop_interleave();
        test_same_cycle();
        test_gp_bypass();
        test_timeout();
        test_start_priority();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_test_monitor.md
Name: rv_test_monitor

Overview:
- Synthesizable end-of-test monitor for the riscvboy platform; replaces fixed-delay simulation with event-driven termination.
- Snoops the core's data-store bus, the register-file write port and the retire stream.
- Detects riscv-tests termination in two ways: a `tohost` store, or the core parking in a self-loop. On the self-loop path it evaluates the shadowed gp (x3) value.
- Reports pass/fail/timeout, the failing test number, and cycle/retire counts. It sits beside the core, so the same verdict logic serves simulation benches and FPGA status LEDs.

Parameters:
- ADDR_W, 32, address width of the store bus and PC.
- DATA_W, 32, data width of the store and register-file buses.
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word.
- EN_TOHOST, 1, 1 enables tohost-store detection.
- EN_LOOP, 1, 1 enables self-loop detection using gp.
- LOOP_LIMIT, 8, consecutive same-PC retires that count as a self-loop (≥2).
- TIMEOUT_CYCLES, 1000, RUN cycles before timeout (≥1).
- CNT_W, 32, width of the cycle and retire counters.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear and arm the monitor
- dbus_we  in  1  store strobe, valid for one cycle
- dbus_addr  in  ADDR_W  store address
- dbus_wdata  in  DATA_W  store data
- rf_we  in  1  register-file write enable
- rf_waddr  in  5  register-file write index
- rf_wdata  in  DATA_W  register-file write data
- ret_valid  in  1  instruction retired this cycle
- ret_pc  in  ADDR_W  PC of the retired instruction
- done  out  1  verdict reached (sticky)
- pass  out  1  test passed (sticky, only with done)
- timeout  out  1  terminated by timeout
- test_num  out  DATA_W  failing test number; 0 on pass or timeout
- cycle_cnt  out  CNT_W  RUN cycles elapsed
- retire_cnt  out  CNT_W  instructions retired in RUN

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is rst_n, asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; gp_shadow, last_pc and loop_cnt all 0. Asserting rst_n low mid-run aborts immediately to IDLE.
- States:
  - IDLE: inputs ignored.
  - RUN: monitoring active.
  - PASS, FAIL, TOUT: terminal; outputs held.
- Transitions:
  - start in any state → RUN next cycle. Counters, gp_shadow, loop_cnt and all verdict outputs clear.
  - start has priority over every same-cycle trigger.
- RUN, each cycle:
  - cycle_cnt += 1.
  - retire_cnt += 1 on ret_valid; saturates at all-ones.
  - gp_shadow <= rf_wdata on rf_we && rf_waddr==3. Writes to x0 are ignored.
- tohost trigger (EN_TOHOST): dbus_we && dbus_addr==TOHOST_ADDR && dbus_wdata[0]==1.
  - wdata==1 → PASS.
  - Otherwise → FAIL, test_num = wdata>>1.
  - A tohost store with wdata[0]==0 is ignored.
- Loop trigger (EN_LOOP):
  - On ret_valid: ret_pc==last_pc increments loop_cnt; any other PC resets loop_cnt to 1. last_pc <= ret_pc.
  - When loop_cnt reaches LOOP_LIMIT, evaluate gp, including any same-cycle gp write (the bypassed value):
    - gp==1 → PASS.
    - Otherwise → FAIL, test_num = gp>>1.
- Timeout trigger: cycle_cnt == TIMEOUT_CYCLES-1 while in RUN → TOUT; timeout=1, pass=0, test_num=0.
- Same-cycle priority: tohost > loop > timeout.
- Output timing:
  - All outputs are registered. done/pass/timeout/test_num become visible exactly one cycle after the trigger cycle.
  - cycle_cnt and retire_cnt freeze on entry to a terminal state. The trigger cycle itself is counted.
- Terminal states ignore all snooped inputs until start or reset.
- With both EN_TOHOST=0 and EN_LOOP=0, only timeout can end a run.

Test Plan:
- Reset, start, store 0x1 to TOHOST_ADDR at RUN cycle 50 → done=1, pass=1, test_num=0, cycle_cnt=51, one cycle later.
- Write x3=0x0B, then retire PC 0x200 eight times consecutively → done=1, pass=0, test_num=5.
- Write x3=1, then 8 same-PC retires interleaved with idle cycles → pass=1. A different PC at the 5th retire restarts the loop count, so the verdict is delayed accordingly.
- Same cycle: tohost store 0x7 and 8th loop retire with gp=1 → FAIL, test_num=3 (tohost wins).
- No trigger, TIMEOUT_CYCLES=1000 → done=1, timeout=1, pass=0, cycle_cnt=1000, then frozen for 100 further cycles.
- Pull rst_n low mid-RUN → all outputs 0 asynchronously. A tohost store after release without start → no verdict. A subsequent start rearms with counters at 0.
